cpu_oci_dct_ctrl: RTL and testbench

- Sequencer for the OCI data-capture-trace (DCT) path of each Nios II core.
- Packs 2-bit trace atoms into a 30-bit DCT buffer with a 4-bit atom count, closes frames on full/flush, and writes them to the on-chip trace RAM through a valid/ready port.
- Owns arm/stop sequencing, the trace RAM write address (wrap or stop-on-full), and the sticky status flags read back over JTAG.

---
 rtl/cpu_oci_dct_pkg.sv | 24 ++
 rtl/cpu_oci_dct_packer.sv | 78 +++++++
 rtl/cpu_oci_dct_ctrl.sv | 146 ++++++++++++++
 tb/tb_cpu_oci_dct_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_oci_dct_pkg.sv
// Shared types and constants for the Nios II OCI data-capture-trace sequencer.
// The frame type is the exact word written to the trace RAM: {count, buffer}.
package cpu_oci_dct_pkg;

  localparam int ATOM_W  = 2;
  localparam int ATOMS   = 15;
  localparam int BUF_W   = ATOM_W * ATOMS;
  localparam int CNT_W   = 4;
  localparam int ADDR_W  = 7;
  localparam int FRAME_W = CNT_W + BUF_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_STOPPED = 2'd3
  } dctState_e;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [BUF_W-1:0] buffer;
  } dctFrame_t;

endpackage

// File: rtl/cpu_oci_dct_packer.sv
// Atom packing buffer: shifts 2-bit trace atoms into a 30-bit word and decides
// when a frame closes (full or flush) and whether it can be handed off.
module cpu_oci_dct_packer
  import cpu_oci_dct_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              captureEn_i,
  input  logic              atomValid_i,
  input  logic [ATOM_W-1:0] atomData_i,
  input  logic              flushReq_i,
  input  logic              canLoad_i,
  input  logic              clear_i,
  output logic [BUF_W-1:0]  buffer_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              close_o,
  output logic              drop_o,
  output dctFrame_t         frame_o
);

  logic [BUF_W-1:0] buffer_q, buffer_d, bufferNext;
  logic [CNT_W-1:0] count_q, count_d, countNext;
  logic             atomTake;
  logic             fullHit;
  logic             flushHit;
  logic             closeWant;

  // The frame always reflects the buffer including this cycle's atom, so a
  // flush that coincides with an atom captures it.
  always_comb begin
    bufferNext = buffer_q;
    countNext  = count_q;
    atomTake   = captureEn_i && atomValid_i;
    if (atomTake) begin
      for (int i = 0; i < ATOMS; i++) begin
        if (count_q == CNT_W'(i)) begin
          bufferNext[i*ATOM_W +: ATOM_W] = atomData_i;
        end
      end
      countNext = count_q + CNT_W'(1);
    end

    fullHit   = atomTake && (countNext == CNT_W'(ATOMS));
    flushHit  = captureEn_i && flushReq_i && (countNext != '0);
    closeWant = fullHit || flushHit;
    close_o   = closeWant && canLoad_i;
    drop_o    = closeWant && !canLoad_i;

    frame_o.count  = countNext;
    frame_o.buffer = bufferNext;

    // A blocked full close holds at ATOMS-1 (dropping the atom); a blocked
    // flush has nowhere to go, so the partial frame is abandoned.
    buffer_d = bufferNext;
    count_d  = countNext;
    if (clear_i || close_o || (drop_o && flushHit)) begin
      buffer_d = '0;
      count_d  = '0;
    end else if (drop_o) begin
      buffer_d = buffer_q;
      count_d  = count_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buffer_q <= '0;
      count_q  <= '0;
    end else begin
      buffer_q <= buffer_d;
      count_q  <= count_d;
    end
  end

  assign buffer_o = buffer_q;
  assign count_o  = count_q;

endmodule

// File: rtl/cpu_oci_dct_ctrl.sv
// OCI DCT sequencer top: arm/stop FSM, one-deep frame register with a
// valid/ready trace RAM port, write address and sticky JTAG status flags.
module cpu_oci_dct_ctrl
  import cpu_oci_dct_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               cfg_enable_i,
  input  logic               cfg_wrap_i,
  input  logic               arm_i,
  input  logic               stop_i,
  input  logic               atom_valid_i,
  input  logic [ATOM_W-1:0]  atom_data_i,
  output logic [BUF_W-1:0]   dct_buffer_o,
  output logic [CNT_W-1:0]   dct_count_o,
  output logic               tw_valid_o,
  input  logic               tw_ready_i,
  output logic [ADDR_W-1:0]  tw_addr_o,
  output logic [FRAME_W-1:0] tw_data_o,
  output logic [1:0]         state_o,
  output logic               trace_wrapped_o,
  output logic               trace_full_o,
  output logic               overflow_o
);

  dctState_e         state_q;
  logic              frameValid_q;
  dctFrame_t         frame_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wrapped_q;
  logic              full_q;
  logic              overflow_q;

  logic      flushReq;
  logic      armStart;
  logic      twAccept;
  logic      atLast;
  logic      wrapEvent;
  logic      stopFull;
  logic      canLoad;
  logic      captureEn;
  logic      packClose;
  logic      packDrop;
  logic      loadFrame;
  dctFrame_t closeFrame;

  assign flushReq  = stop_i || !cfg_enable_i;
  assign armStart  = ((state_q == ST_IDLE) || (state_q == ST_STOPPED)) &&
                     arm_i && cfg_enable_i && !stop_i;
  assign twAccept  = frameValid_q && tw_ready_i;
  assign atLast    = (addr_q == {ADDR_W{1'b1}});
  assign wrapEvent = twAccept && atLast;
  assign stopFull  = wrapEvent && !cfg_wrap_i;
  assign canLoad   = !frameValid_q || twAccept;
  assign captureEn = (state_q == ST_CAPTURE);
  assign loadFrame = packClose && !stopFull;

  // Reaching the end of RAM discards whatever partial frame is being packed.
  cpu_oci_dct_packer u_packer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .captureEn_i (captureEn),
    .atomValid_i (atom_valid_i),
    .atomData_i  (atom_data_i),
    .flushReq_i  (flushReq),
    .canLoad_i   (canLoad),
    .clear_i     (armStart || wrapEvent),
    .buffer_o    (dct_buffer_o),
    .count_o     (dct_count_o),
    .close_o     (packClose),
    .drop_o      (packDrop),
    .frame_o     (closeFrame)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_STOPPED: begin
          if (armStart) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (stopFull)      state_q <= ST_STOPPED;
          else if (flushReq) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (stopFull)           state_q <= ST_STOPPED;
          else if (!frameValid_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A frame loading on the same edge the previous one is accepted keeps
  // tw_valid high with no bubble; a stop-on-full edge drops it instead.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      frameValid_q <= 1'b0;
      frame_q      <= '0;
      addr_q       <= '0;
      wrapped_q    <= 1'b0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (armStart) begin
        addr_q     <= '0;
        wrapped_q  <= 1'b0;
        full_q     <= 1'b0;
        overflow_q <= 1'b0;
      end

      if (stopFull) begin
        frameValid_q <= 1'b0;
      end else if (loadFrame) begin
        frameValid_q <= 1'b1;
        frame_q      <= closeFrame;
      end else if (twAccept) begin
        frameValid_q <= 1'b0;
      end

      if (twAccept) begin
        if (!atLast) begin
          addr_q <= addr_q + ADDR_W'(1);
        end else if (cfg_wrap_i) begin
          addr_q    <= '0;
          wrapped_q <= 1'b1;
        end else begin
          full_q <= 1'b1;
        end
      end

      if (packDrop) overflow_q <= 1'b1;
    end
  end

  assign tw_valid_o      = frameValid_q;
  assign tw_addr_o       = addr_q;
  assign tw_data_o       = frame_q;
  assign state_o         = state_q;
  assign trace_wrapped_o = wrapped_q;
  assign trace_full_o    = full_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_cpu_oci_dct_ctrl.sv
// Self-checking bench for cpu_oci_dct_ctrl: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model of the tracer.
module tb_cpu_oci_dct_ctrl;

  localparam int M_IDLE    = 0;
  localparam int M_CAPTURE = 1;
  localparam int M_DRAIN   = 2;
  localparam int M_STOPPED = 3;
  localparam int LAST_ADDR = 127;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfgEnable, cfgWrap, arm, stop, atomValid, twReady;
  logic [1:0]  atomData;
  logic [29:0] dctBuffer;
  logic [3:0]  dctCount;
  logic        twValid;
  logic [6:0]  twAddr;
  logic [33:0] twData;
  logic [1:0]  state;
  logic        traceWrapped, traceFull, overflow;

  int checkCount = 0;
  int passCount  = 0;
  int accCount   = 0;
  int lastAccAddr = -1;

  // Behavioural model: the packing buffer is just a queue of atoms.
  int          mState;
  int          mQ[$];
  bit          mValid;
  logic [3:0]  mCnt;
  logic [29:0] mBuf;
  int          mAddr;
  bit          mWrapped, mFull, mOvf;

  cpu_oci_dct_ctrl dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .cfg_enable_i    (cfgEnable),
    .cfg_wrap_i      (cfgWrap),
    .arm_i           (arm),
    .stop_i          (stop),
    .atom_valid_i    (atomValid),
    .atom_data_i     (atomData),
    .dct_buffer_o    (dctBuffer),
    .dct_count_o     (dctCount),
    .tw_valid_o      (twValid),
    .tw_ready_i      (twReady),
    .tw_addr_o       (twAddr),
    .tw_data_o       (twData),
    .state_o         (state),
    .trace_wrapped_o (traceWrapped),
    .trace_full_o    (traceFull),
    .overflow_o      (overflow)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic logic [29:0] packAtoms(input int q[$]);
    logic [29:0] b = '0;
    foreach (q[i]) b = b | (30'(q[i] & 3) << (2 * i));
    return b;
  endfunction

  task automatic modelReset();
    mState = M_IDLE; mQ.delete(); mValid = 0; mCnt = '0; mBuf = '0;
    mAddr = 0; mWrapped = 0; mFull = 0; mOvf = 0;
  endtask

  task automatic modelStep(input bit en, input bit wrap, input bit armIn, input bit stopIn,
                           input bit av, input logic [1:0] ad, input bit rdy);
    bit accept, wrapEv, flush, newFrame;
    int atoms[$];
    int nextState;
    logic [3:0]  nc;
    logic [29:0] nb;
    accept    = mValid && rdy;
    wrapEv    = accept && (mAddr == LAST_ADDR);
    flush     = stopIn || !en;
    newFrame  = 0;
    nc        = '0;
    nb        = '0;
    nextState = mState;
    case (mState)
      M_IDLE, M_STOPPED: begin
        if (armIn && en && !stopIn) begin
          mQ.delete(); mAddr = 0; mWrapped = 0; mFull = 0; mOvf = 0;
          nextState = M_CAPTURE;
        end
      end
      M_CAPTURE: begin
        atoms = mQ;
        if (av) atoms.push_back(int'(ad));
        if ((av && atoms.size() == 15) || (flush && atoms.size() > 0)) begin
          if (!mValid || accept) begin
            newFrame = 1; nc = 4'(atoms.size()); nb = packAtoms(atoms); mQ.delete();
          end else begin
            mOvf = 1;
            if (flush) mQ.delete();
          end
        end else begin
          mQ = atoms;
        end
        if (flush) nextState = M_DRAIN;
      end
      default: begin
        if (!mValid) nextState = M_IDLE;
      end
    endcase
    if (accept) begin
      if (wrapEv) begin
        mQ.delete();
        if (wrap) begin
          mAddr = 0; mWrapped = 1;
        end else begin
          mFull = 1; nextState = M_STOPPED; newFrame = 0;
        end
      end else begin
        mAddr++;
      end
    end
    if (newFrame) begin
      mValid = 1; mCnt = nc; mBuf = nb;
    end else if (accept) begin
      mValid = 0;
    end
    mState = nextState;
  endtask

  task automatic checkAll();
    checkOutput("state", 64'(state), 64'(mState));
    checkOutput("twValid", 64'(twValid), 64'(mValid));
    if (mValid) checkOutput("twData", 64'(twData), 64'({mCnt, mBuf}));
    checkOutput("twAddr", 64'(twAddr), 64'(mAddr));
    checkOutput("dctCount", 64'(dctCount), 64'(mQ.size()));
    checkOutput("dctBuffer", 64'(dctBuffer), 64'(packAtoms(mQ)));
    checkOutput("wrapped", 64'(traceWrapped), 64'(mWrapped));
    checkOutput("full", 64'(traceFull), 64'(mFull));
    checkOutput("overflow", 64'(overflow), 64'(mOvf));
  endtask

  task automatic applyStimulus(input bit en, input bit wrap, input bit armIn, input bit stopIn,
                               input bit av, input logic [1:0] ad, input bit rdy);
    cfgEnable = en; cfgWrap = wrap; arm = armIn; stop = stopIn;
    atomValid = av; atomData = ad; twReady = rdy;
    if (twValid && rdy) begin
      accCount++;
      lastAccAddr = int'(twAddr);
    end
    modelStep(en, wrap, armIn, stopIn, av, ad, rdy);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic drainToIdle(input bit wrap);
    for (int i = 0; i < 10 && state != 2'd0; i++) applyStimulus(1, wrap, 0, 0, 0, 2'd0, 1);
    checkOutput("drainIdle", 64'(state), 64'(M_IDLE));
  endtask

  initial begin
    int bpAtoms[$];
    int q2[$];
    logic [1:0] d;
    logic [33:0] firstFrame;
    bit segWrap;

    reset = 1'b1; cfgEnable = 0; cfgWrap = 0; arm = 0; stop = 0;
    atomValid = 0; atomData = '0; twReady = 0;
    modelReset();
    #12;
    checkAll();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full frame of 2'b01 atoms
    applyStimulus(1, 1, 1, 0, 0, 2'd0, 1);
    checkOutput("armState", 64'(state), 64'(M_CAPTURE));
    for (int i = 0; i < 15; i++) applyStimulus(1, 1, 0, 0, 1, 2'b01, 1);
    checkOutput("fullFrameValid", 64'(twValid), 64'd1);
    checkOutput("fullFrameData", 64'(twData), 64'({4'd15, {15{2'b01}}}));
    checkOutput("fullFrameAddr", 64'(twAddr), 64'd0);
    checkOutput("fullFrameCount", 64'(dctCount), 64'd0);
    applyStimulus(1, 1, 0, 0, 0, 2'd0, 1);
    checkOutput("addrAfterWrite", 64'(twAddr), 64'd1);

    // Flush with an atom in the same cycle
    applyStimulus(1, 1, 0, 0, 1, 2'd1, 1);
    applyStimulus(1, 1, 0, 0, 1, 2'd2, 1);
    applyStimulus(1, 1, 0, 0, 1, 2'd3, 1);
    applyStimulus(1, 1, 0, 1, 1, 2'd0, 1);
    checkOutput("flushFrame", 64'(twData), 64'({4'd4, 30'h39}));
    checkOutput("flushDrain", 64'(state), 64'(M_DRAIN));
    drainToIdle(1);

    // Backpressure and overflow, then a no-bubble handoff
    applyStimulus(1, 1, 1, 0, 0, 2'd0, 0);
    for (int i = 0; i < 30; i++) begin
      d = 2'($urandom_range(0, 3));
      bpAtoms.push_back(int'(d));
      applyStimulus(1, 1, 0, 0, 1, d, 0);
      if (i == 14) firstFrame = {4'd15, packAtoms(bpAtoms)};
    end
    checkOutput("bpHeld", 64'(twData), 64'(firstFrame));
    checkOutput("bpOverflow", 64'(overflow), 64'd1);
    checkOutput("bpCount", 64'(dctCount), 64'd14);
    d = 2'($urandom_range(0, 3));
    q2 = bpAtoms[15:28];
    q2.push_back(int'(d));
    applyStimulus(1, 1, 0, 0, 1, d, 1);
    checkOutput("noBubbleValid", 64'(twValid), 64'd1);
    checkOutput("noBubbleAddr", 64'(twAddr), 64'd1);
    checkOutput("noBubbleData", 64'(twData), 64'({4'd15, packAtoms(q2)}));
    applyStimulus(1, 1, 0, 1, 0, 2'd0, 1);
    drainToIdle(1);

    // Stop on full RAM
    applyStimulus(1, 0, 1, 0, 0, 2'd0, 1);
    for (int i = 0; i < 3000 && state != 2'd3; i++)
      applyStimulus(1, 0, 0, 0, 1, 2'($urandom_range(0, 3)), 1);
    checkOutput("fullState", 64'(state), 64'(M_STOPPED));
    checkOutput("fullFlag", 64'(traceFull), 64'd1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 1, 2'd3, 1);
    checkOutput("stoppedCount", 64'(dctCount), 64'd0);
    checkOutput("stoppedValid", 64'(twValid), 64'd0);

    // Wrap: 129th frame lands at address 0
    applyStimulus(1, 1, 1, 0, 0, 2'd0, 1);
    accCount = 0;
    for (int i = 0; i < 3000 && accCount < 129; i++)
      applyStimulus(1, 1, 0, 0, 1, 2'($urandom_range(0, 3)), 1);
    checkOutput("wrapWrites", 64'(accCount), 64'd129);
    checkOutput("wrapAddr", 64'(lastAccAddr), 64'd0);
    checkOutput("wrapFlag", 64'(traceWrapped), 64'd1);
    applyStimulus(1, 1, 0, 1, 0, 2'd0, 1);
    drainToIdle(1);

    // Asynchronous reset with a frame pending and 7 atoms packed
    applyStimulus(1, 1, 1, 0, 0, 2'd0, 0);
    for (int i = 0; i < 22; i++) applyStimulus(1, 1, 0, 0, 1, 2'($urandom_range(0, 3)), 0);
    checkOutput("preResetCount", 64'(dctCount), 64'd7);
    checkOutput("preResetValid", 64'(twValid), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("rstState", 64'(state), 64'd0);
    checkOutput("rstValid", 64'(twValid), 64'd0);
    checkOutput("rstData", 64'(twData), 64'd0);
    checkOutput("rstAddr", 64'(twAddr), 64'd0);
    checkOutput("rstCount", 64'(dctCount), 64'd0);
    checkOutput("rstBuffer", 64'(dctBuffer), 64'd0);
    checkOutput("rstFlags", 64'({traceWrapped, traceFull, overflow}), 64'd0);
    modelReset();
    #2;
    reset = 1'b0;

    // Random traffic
    segWrap = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) segWrap = 1'($urandom_range(0, 1));
      applyStimulus(($urandom % 20) != 0, segWrap, ($urandom % 15) == 0, ($urandom % 25) == 0,
                    ($urandom % 10) < 7, 2'($urandom_range(0, 3)), ($urandom % 10) < 6);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
